// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: synchronises N_CH raw inputs, detects enabled rise/fall edges
// and serialises them round-robin onto a single valid/ready event port.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] a,
  input  logic [N_CH-1:0] rise_en,
  input  logic [N_CH-1:0] fall_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr,
  output logic            busy
);

  // state   | meaning
  // IDLE    | no event on the port; grant the next pending channel if any
  // PRESENT | event held on evt_ch/evt_rise until the consumer takes it
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] prev;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] ptype;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] edge_det;
  logic [N_CH-1:0] drop;
  logic [N_CH-1:0] keep;
  logic [N_CH-1:0] load_vec;
  logic [1:0]      prime_cnt;
  logic            primed;
  logic [0:0]      state;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant;
  logic            grant_found;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= N_CH) j = j - N_CH;
    return CH_W'(j);
  endfunction

  // Edges are suppressed until prev holds a value that came through the
  // synchroniser, so a level held across reset never looks like an edge.
  assign rise     = primed ? (s & ~prev & rise_en) : '0;
  assign fall     = primed ? (~s & prev & fall_en) : '0;
  assign edge_det = rise | fall;
  assign drop     = edge_det & pend & ~load_vec;
  assign keep     = edge_det & ~drop;
  assign load_vec = (state == IDLE && grant_found) ? ({{(N_CH-1){1'b0}}, 1'b1} << grant) : '0;
  assign busy     = (|pend) | evt_valid;

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_found && pend[wrap_add(rr_ptr, k)]) begin
        grant       = wrap_add(rr_ptr, k);
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      s         <= '0;
      prev      <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
      pend      <= '0;
      ptype     <= '0;
      ovf       <= '0;
      state     <= IDLE;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
    end else begin
      sync1 <= a;
      s     <= sync1;
      prev  <= s;
      if (!primed) begin
        prime_cnt <= prime_cnt + 2'd1;
        primed    <= (prime_cnt == 2'd2);
      end
      pend  <= (pend & ~load_vec) | edge_det;
      ptype <= (ptype & ~keep) | (rise & keep);
      ovf   <= drop | (ovf & ~ovf_clr);
      case (state)
        IDLE: begin
          if (grant_found) begin
            evt_valid <= 1'b1;
            evt_ch    <= grant;
            evt_rise  <= ptype[grant];
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            rr_ptr    <= wrap_add(evt_ch, 1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
